nybble_alu: RTL
===============

# nybble_alu

Nybble-serial 8-bit arithmetic/logic unit for the CPU datapath. It sits directly upstream of the decimal-adjust stage and produces the accumulator value and the {Z,N,H,C} flag nybble that the decimal-adjust stage consumes. Operations run in two passes, low nybble then high nybble, with the nybble carry held in a register between passes. A start/busy/done handshake connects it to the control unit.

## Interface
Parameters: none.
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  request; accepted in IDLE or DONE
- i_op  in  4  opcode: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 INC, 9 DEC, A CPL, B SCF, C CCF, D–F NOP
- i_A  in  8  accumulator operand
- i_B  in  8  second operand; sole operand for INC/DEC
- i_F  in  4  current flags {Z,N,H,C} at [3:0]
- o_busy  out  1  high in LO and HI
- o_done  out  1  one-cycle pulse; o_result, o_F and o_wr_en are valid
- o_result  out  8  result
- o_F  out  4  new flags {Z,N,H,C}, same bit order as i_F
- o_wr_en  out  1  destination write enable; 0 for CP and NOP

## Operation
- FSM states: IDLE, LO, HI, DONE.
  - IDLE → LO on i_start.
  - LO → HI unconditionally.
  - HI → DONE unconditionally.
  - DONE → LO if i_start, otherwise IDLE.
- On accept, latch i_op, i_A, i_B and i_F. Inputs may change freely while busy.
- i_start is ignored in LO and HI.
- LO pass:
  - Compute bits [3:0].
  - The carry-in is C for ADC/SBC; for SUB/SBC/CP/DEC it acts as a borrow.
  - Store the nybble carry or borrow from bit 3 as H.
- HI pass: compute bits [7:4] using the stored nybble carry as carry-in. The carry out of bit 7 is C.
- Arithmetic is 8-bit and wraps modulo 256. SUB-class ops set C on borrow (B + cin > A).
- Flag rules:
  - ADD/ADC: Z = result==0, N=0, H, C.
  - SUB/SBC/CP: Z = result==0, N=1, H, C.
  - CP: o_result = A−B, o_wr_en=0.
  - AND: Z, N=0, H=1, C=0.
  - XOR/OR: Z, N=0, H=0, C=0.
  - INC: result = B+1; Z, N=0, H; C unchanged.
  - DEC: result = B−1; Z, N=1, H = borrow from bit 4; C unchanged.
  - CPL: result = ~A; N=1, H=1; Z and C unchanged.
  - SCF: result = A; N=0, H=0, C=1; Z unchanged.
  - CCF: result = A; N=0, H=0, C=~C; Z unchanged.
  - NOP: result = A, flags unchanged, o_wr_en=0.
- Logic ops and CPL/SCF/CCF/NOP also pass through LO/HI, so latency is uniform for all opcodes.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system): state IDLE, o_busy=0, o_done=0, o_result=0x00, o_F=4'b0000, o_wr_en=0.
- Reset mid-operation aborts the operation. No o_done is produced.
- Latency: i_start sampled at edge N; o_busy is high during cycles N→N+2; o_done is high for exactly the cycle after edge N+2.
- o_result, o_F and o_wr_en update only on entry to DONE. They hold until the next DONE.
- Back-to-back: i_start in DONE gives the next o_done 3 cycles after the previous one. Throughput is one op per 3 cycles.

## Configuration
- NYBBLE_ALU_SINGLE_CYCLE_EN defined:
  - Full 8-bit compute in one pass; IDLE → DONE directly.
  - o_done follows i_start by one edge.
  - o_busy is tied to 0.
  - Flags are identical to the serial mode.
- Undefined: nybble-serial operation as specified above.

## Test plan
- ADD A=0x45, B=0x38 → o_result 0x7D, o_F 4'b0000, o_wr_en 1, o_done 3 cycles after start.
- ADD A=0x3A, B=0xC6 → 0x00, o_F 4'b1011. SUB A=0x10, B=0x01 → 0x0F, o_F 4'b0110.
- SBC A=0x00, B=0x00, i_F C=1 → 0xFF, o_F 4'b0111. CP A=0x42, B=0x42 → o_F 4'b1100, o_wr_en 0.
- INC B=0xFF, i_F=4'b0001 → 0x00, o_F 4'b1011. CCF with i_F=4'b1111 → o_F 4'b1000, result = A.
- i_start pulsed during LO/HI → ignored, single o_done. i_start held in DONE → second o_done 3 cycles later with the new operands.
- i_rst_n low during HI → outputs zero immediately, no o_done. A start after release completes normally.

Source files
------------

// File: rtl/nybble_alu.sv
// nybble_alu: nybble-serial 8-bit ALU feeding the decimal-adjust stage.
// An accepted request runs two passes, low nybble (LO) then high nybble (HI),
// with the nybble carry/borrow held between them. Results commit on entry to DONE.
// Ports:
//   i_clk, i_rst_n         clock (rising edge), async active-low reset
//   i_start                request, accepted in IDLE or DONE
//   i_op[3:0]              opcode (ADD ADC SUB SBC AND XOR OR CP INC DEC CPL SCF CCF, D-F NOP)
//   i_A[7:0], i_B[7:0]     operands (i_B is the sole operand for INC/DEC)
//   i_F[3:0]               current flags {Z,N,H,C}
//   o_busy                 high while in LO or HI
//   o_done                 one-cycle pulse, outputs valid
//   o_result[7:0], o_F[3:0], o_wr_en   committed result, flags, write enable
// Build option: define NYBBLE_ALU_SINGLE_CYCLE_EN to compute all 8 bits in one
// pass (IDLE -> DONE directly, o_busy tied low, identical flags).
module nybble_alu (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_op,
  input  logic [7:0] i_A,
  input  logic [7:0] i_B,
  input  logic [3:0] i_F,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_result,
  output logic [3:0] o_F,
  output logic       o_wr_en
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP,
    OP_INC, OP_DEC, OP_CPL, OP_SCF, OP_CCF, OP_NOP
  } op_e;

  // INC/DEC operate on B with a constant 1; everything else uses A (and B).
  function automatic logic [7:0] src_x(op_e op, logic [7:0] a, logic [7:0] b);
    return (op == OP_INC || op == OP_DEC) ? b : a;
  endfunction

  function automatic logic [7:0] src_y(op_e op, logic [7:0] b);
    return (op == OP_INC || op == OP_DEC) ? 8'h01 : b;
  endfunction

  function automatic logic carry_in(op_e op, logic [3:0] f);
    return (op == OP_ADC || op == OP_SBC) ? f[0] : 1'b0;
  endfunction

  // One nybble pass: {carry/borrow out, 4-bit result}. For the subtract class,
  // bit 4 of the 5-bit difference is the borrow.
  function automatic logic [4:0] nyb_step(op_e op, logic [3:0] x, logic [3:0] y, logic cin);
    logic [4:0] r;
    r = {1'b0, x};
    case (op)
      OP_ADD, OP_ADC, OP_INC:        r = {1'b0, x} + {1'b0, y} + {4'b0, cin};
      OP_SUB, OP_SBC, OP_CP, OP_DEC: r = {1'b0, x} - {1'b0, y} - {4'b0, cin};
      OP_AND:                        r = {1'b0, x & y};
      OP_XOR:                        r = {1'b0, x ^ y};
      OP_OR:                         r = {1'b0, x | y};
      OP_CPL:                        r = {1'b0, ~x};
      default:                       r = {1'b0, x};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] new_flags(op_e op, logic [7:0] res, logic h, logic c,
                                           logic [3:0] f);
    logic z;
    logic [3:0] nf;
    z  = (res == 8'h00);
    nf = f;
    case (op)
      OP_ADD, OP_ADC:        nf = {z, 1'b0, h, c};
      OP_SUB, OP_SBC, OP_CP: nf = {z, 1'b1, h, c};
      OP_AND:                nf = {z, 3'b010};
      OP_XOR, OP_OR:         nf = {z, 3'b000};
      OP_INC:                nf = {z, 1'b0, h, f[0]};
      OP_DEC:                nf = {z, 1'b1, h, f[0]};
      OP_CPL:                nf = {f[3], 2'b11, f[0]};
      OP_SCF:                nf = {f[3], 3'b001};
      OP_CCF:                nf = {f[3], 2'b00, ~f[0]};
      default:               nf = f;
    endcase
    return nf;
  endfunction

  function automatic logic write_en(op_e op);
    return !(op == OP_CP || op > OP_CCF);
  endfunction

  state_e     state_q, state_d;
  logic       accept;
  logic       commit;
  op_e        op_s;
  logic [3:0] f_s;
  logic [7:0] x_s, y_s;
  logic [4:0] lo_step, hi_step;
  logic       h_s;
  logic [3:0] lo_res_s;
  logic [7:0] res_s;

  assign accept = i_start && (state_q == IDLE || state_q == DONE);
  assign o_done = (state_q == DONE);
  assign res_s  = {hi_step[3:0], lo_res_s};

`ifdef NYBBLE_ALU_SINGLE_CYCLE_EN
  // Both nybble passes chained combinationally from the live inputs.
  assign op_s     = op_e'(i_op);
  assign f_s      = i_F;
  assign x_s      = src_x(op_s, i_A, i_B);
  assign y_s      = src_y(op_s, i_B);
  assign lo_step  = nyb_step(op_s, x_s[3:0], y_s[3:0], carry_in(op_s, f_s));
  assign hi_step  = nyb_step(op_s, x_s[7:4], y_s[7:4], lo_step[4]);
  assign h_s      = lo_step[4];
  assign lo_res_s = lo_step[3:0];
  assign commit   = accept;
  assign o_busy   = 1'b0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = DONE;
      DONE:    state_d = i_start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
`else
  op_e        op_q;
  logic [7:0] a_q, b_q;
  logic [3:0] f_q;
  logic [3:0] lo_q;
  logic       nc_q;

  assign op_s     = op_q;
  assign f_s      = f_q;
  assign x_s      = src_x(op_s, a_q, b_q);
  assign y_s      = src_y(op_s, b_q);
  assign lo_step  = nyb_step(op_s, x_s[3:0], y_s[3:0], carry_in(op_s, f_s));
  assign hi_step  = nyb_step(op_s, x_s[7:4], y_s[7:4], nc_q);
  assign h_s      = nc_q;
  assign lo_res_s = lo_q;
  assign commit   = (state_q == HI);
  assign o_busy   = (state_q == LO) || (state_q == HI);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    state_d = i_start ? LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
      f_q  <= '0;
      lo_q <= '0;
      nc_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op_e'(i_op);
        a_q  <= i_A;
        b_q  <= i_B;
        f_q  <= i_F;
      end
      if (state_q == LO) begin
        lo_q <= lo_step[3:0];
        nc_q <= lo_step[4];
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      o_result <= '0;
      o_F      <= '0;
      o_wr_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        o_result <= res_s;
        o_F      <= new_flags(op_s, res_s, h_s, hi_step[4], f_s);
        o_wr_en  <= write_en(op_s);
      end
    end
  end

endmodule
